// File: rtl/seq_sub_pkg.sv
// ---------------------------------------------------------------------------
// seq_sub_pkg
// Shared types and defaults for the chunked sequential subtractor.
//   sub_state_e      : control FSM states (idle / busy / done)
//   DEF_DATA_WIDTH   : default operand width
//   DEF_CHUNK_WIDTH  : default bits processed per cycle
//   idx_width()      : width of a counter able to index n chunks (min 1 bit)
// ---------------------------------------------------------------------------
package seq_sub_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } sub_state_e;

   localparam int DEF_DATA_WIDTH  = 16;
   localparam int DEF_CHUNK_WIDTH = 4;

   // A single-chunk configuration still needs a 1-bit index register.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage : seq_sub_pkg

// File: rtl/sub_chunk.sv
// ---------------------------------------------------------------------------
// sub_chunk
// Combinational CHUNK_WIDTH-bit subtract stage: d = a - b - borrow_in.
// Ports:
//   a, b        in   CHUNK_WIDTH  minuend / subtrahend chunk
//   borrow_in   in   1            borrow from the previous (less significant) chunk
//   d           out  CHUNK_WIDTH  difference chunk
//   borrow_out  out  1            1 when a < b + borrow_in
// ---------------------------------------------------------------------------
module sub_chunk #(
   parameter int CHUNK_WIDTH = 4
) (
   input  logic [CHUNK_WIDTH-1:0] a,
   input  logic [CHUNK_WIDTH-1:0] b,
   input  logic                   borrow_in,
   output logic [CHUNK_WIDTH-1:0] d,
   output logic                   borrow_out
);

   // One extra bit: a negative result wraps and sets the top bit, which is the borrow.
   logic [CHUNK_WIDTH:0] w_full;

   assign w_full     = {1'b0, a} - {1'b0, b} - {{CHUNK_WIDTH{1'b0}}, borrow_in};
   assign d          = w_full[CHUNK_WIDTH-1:0];
   assign borrow_out = w_full[CHUNK_WIDTH];

endmodule : sub_chunk

// File: rtl/seq_subtractor.sv
// ---------------------------------------------------------------------------
// seq_subtractor
// Multi-cycle unsigned subtractor: diff = a_in - b_in, CHUNK_WIDTH bits per
// cycle, least significant chunk first, borrow rippled between cycles.
// Valid/ready handshakes on both sides; one operation in flight at a time.
//
// Ports:
//   clk         in   1           clock, rising edge
//   rst         in   1           synchronous reset, active-high
//   ebl         in   1           enable; 0 freezes all state, no handshake completes
//   in_valid    in   1           operands valid
//   in_ready    out  1           block can accept operands (idle and enabled)
//   a_in        in   DATA_WIDTH  minuend
//   b_in        in   DATA_WIDTH  subtrahend
//   out_valid   out  1           result valid (done and enabled)
//   out_ready   in   1           downstream accepts result
//   diff        out  DATA_WIDTH  result (registered; only meaningful with out_valid)
//   borrow_out  out  1           1 = a_in < b_in
//
// Build option:
//   SEQ_SUB_SATURATE_EN  when defined, an underflowing result is clamped to 0
//                        (borrow_out still reports the underflow). Timing and
//                        handshake are the same in both builds.
// ---------------------------------------------------------------------------
module seq_subtractor
   import seq_sub_pkg::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int CHUNK_WIDTH = DEF_CHUNK_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ebl,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] a_in,
   input  logic [DATA_WIDTH-1:0] b_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] diff,
   output logic                  borrow_out
);

   localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
   localparam int IDX_W      = idx_width(NUM_CHUNKS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

   generate
      if (DATA_WIDTH % CHUNK_WIDTH != 0) begin : g_bad_cfg
         $fatal(1, "seq_subtractor: DATA_WIDTH must be a multiple of CHUNK_WIDTH");
      end
   endgenerate

   sub_state_e             r_state;
   logic [IDX_W-1:0]       r_idx;
   logic [DATA_WIDTH-1:0]  r_a;
   logic [DATA_WIDTH-1:0]  r_b;
   logic                   r_borrow;
   logic [DATA_WIDTH-1:0]  r_diff;
   logic                   r_borrow_out;

   logic [CHUNK_WIDTH-1:0] w_a_ch [NUM_CHUNKS];
   logic [CHUNK_WIDTH-1:0] w_b_ch [NUM_CHUNKS];
   logic [CHUNK_WIDTH-1:0] w_a_sel;
   logic [CHUNK_WIDTH-1:0] w_b_sel;
   logic [CHUNK_WIDTH-1:0] w_d;
   logic                   w_borrow;

   // Split the latched operands into chunk views for the per-cycle mux.
   for (genvar gi = 0; gi < NUM_CHUNKS; gi++) begin : g_chunks
      assign w_a_ch[gi] = r_a[gi*CHUNK_WIDTH +: CHUNK_WIDTH];
      assign w_b_ch[gi] = r_b[gi*CHUNK_WIDTH +: CHUNK_WIDTH];
   end

   always_comb begin
      w_a_sel = '0;
      w_b_sel = '0;
      for (int k = 0; k < NUM_CHUNKS; k++) begin
         if (r_idx == IDX_W'(k)) begin
            w_a_sel = w_a_ch[k];
            w_b_sel = w_b_ch[k];
         end
      end
   end

   sub_chunk #(
      .CHUNK_WIDTH (CHUNK_WIDTH)
   ) u_sub_chunk (
      .a          (w_a_sel),
      .b          (w_b_sel),
      .borrow_in  (r_borrow),
      .d          (w_d),
      .borrow_out (w_borrow)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_idx        <= '0;
         r_borrow     <= 1'b0;
         r_diff       <= '0;
         r_borrow_out <= 1'b0;
      end else if (ebl) begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a      <= a_in;
                  r_b      <= b_in;
                  r_borrow <= 1'b0;
                  r_idx    <= '0;
                  r_diff   <= '0;
                  r_state  <= S_BUSY;
               end
            end

            S_BUSY: begin
               for (int k = 0; k < NUM_CHUNKS; k++) begin
                  if (r_idx == IDX_W'(k)) begin
                     r_diff[k*CHUNK_WIDTH +: CHUNK_WIDTH] <= w_d;
                  end
               end
               r_borrow <= w_borrow;
               if (r_idx == LAST_IDX) begin
                  r_borrow_out <= w_borrow;
                  r_idx        <= '0;
                  r_state      <= S_DONE;
`ifdef SEQ_SUB_SATURATE_EN
                  // Clamp overrides the chunk write above (last assignment wins).
                  if (w_borrow) begin
                     r_diff <= '0;
                  end
`else
`endif
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end

            S_DONE: begin
               if (out_ready) begin
                  r_state <= S_IDLE;
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Handshake flags follow ebl directly so a disabled block never completes one.
   assign in_ready   = ~rst & ebl & (r_state == S_IDLE);
   assign out_valid  = ~rst & ebl & (r_state == S_DONE);
   assign diff       = r_diff;
   assign borrow_out = r_borrow_out;

endmodule : seq_subtractor
